// File: rtl/i2c_slave_receiver.sv
// Write-only I2C target: collects NUM_BYTES-byte frames addressed to ADDR and publishes them on STOP.
// Define I2C_SLV_GLITCH_FILTER_EN to insert a 3-sample majority filter after the SCL/SDA synchronizers.
//
// state      | meaning
// S_IDLE     | bus free or not addressed, waiting for START
// S_ADDR     | shifting in address + R/W bit
// S_ADDR_ACK | driving ACK for a matching write address
// S_DATA     | shifting in a data byte
// S_DATA_ACK | ACK/NACK slot after a data byte
// S_IGNORE   | transfer not for us, wait for START/STOP
module i2c_slave_receiver #(
  parameter logic [6:0] ADDR      = 7'b0000111,
  parameter int         NUM_BYTES = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i2c_scl,
  inout  wire                    i2c_sda,
  output logic [8*NUM_BYTES-1:0] data_out,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int FRAME_W = 8*NUM_BYTES;
  localparam int CW      = $clog2(NUM_BYTES+1);
  localparam logic [CW-1:0] NB_C      = CW'(NUM_BYTES);
  localparam logic [7:0]    ADDR_WR_C = {ADDR, 1'b0};

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE} state_t;

  logic [1:0]         scl_sync_q, sda_sync_q;
  logic               scl_prev_q, sda_prev_q;
  logic               scl_f, sda_f;
  state_t             state_q, state_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [CW-1:0]      byte_cnt_q, byte_cnt_d;
  logic               ovf_q, ovf_d;
  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               ack_q, ack_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i2c_scl};
      sda_sync_q <= {sda_sync_q[0], i2c_sda};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
    end
  end

  assign scl_f = (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) |
                 (scl_hist_q[0] & scl_hist_q[1]);
  assign sda_f = (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) |
                 (sda_hist_q[0] & sda_hist_q[1]);
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  logic scl_rise, scl_fall, start_det, stop_det, busy_w;

  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  assign start_det = scl_f & sda_prev_q & ~sda_f;
  assign stop_det  = scl_f & ~sda_prev_q & sda_f;
  assign busy_w    = (state_q == S_ADDR_ACK) || (state_q == S_DATA) || (state_q == S_DATA_ACK);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    ovf_d      = ovf_q;
    shadow_d   = shadow_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    ack_d      = ack_q;
    if (start_det) begin
      state_d    = S_ADDR;
      bit_cnt_d  = 4'd0;
      byte_cnt_d = '0;
      ovf_d      = 1'b0;
      shadow_d   = '0;
      ack_d      = 1'b0;
    end else if (stop_det) begin
      if (busy_w) begin
        if (byte_cnt_q == NB_C && !ovf_q) begin
          data_d  = shadow_q;
          valid_d = 1'b1;
        end else if (byte_cnt_q != '0 || ovf_q) begin
          err_d = 1'b1;
        end
      end
      state_d    = S_IDLE;
      bit_cnt_d  = 4'd0;
      byte_cnt_d = '0;
      ovf_d      = 1'b0;
      shadow_d   = '0;
      ack_d      = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (state_q == S_ADDR) begin
              if (shift_q == ADDR_WR_C) begin
                state_d = S_ADDR_ACK;
                ack_d   = 1'b1;
              end else begin
                state_d = S_IGNORE;
              end
            end else begin
              state_d = S_DATA_ACK;
              // a full buffer NACKs and latches overflow instead of storing
              if (byte_cnt_q < NB_C) begin
                shadow_d   = (shadow_q << 8) | FRAME_W'(shift_q);
                byte_cnt_d = byte_cnt_q + 1'b1;
                ack_d      = 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          if (scl_fall) begin
            state_d = S_DATA;
            ack_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      byte_cnt_q <= '0;
      ovf_q      <= 1'b0;
      shadow_q   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      ovf_q      <= ovf_d;
      shadow_q   <= shadow_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
    end
  end

  assign i2c_sda     = ack_q ? 1'b0 : 1'bz;
  assign data_out    = data_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign busy        = busy_w;

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Bench for i2c_slave_receiver: bit-banged I2C master, randomized frames, frame-level reference model.
module tb_i2c_slave_receiver;
  localparam int NB = 13;
  localparam int FW = 8*NB;
  localparam int Q  = 6;
`ifdef I2C_SLV_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda;
  logic [FW-1:0] data_out;
  logic frame_valid, frame_err, busy;

  int cmp_cnt = 0;
  int mis_cnt = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  bit busy_seen = 1'b0;
  logic [7:0] lat_trace;
  logic [FW-1:0] exp_data = '0;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_receiver #(.ADDR(7'h07), .NUM_BYTES(NB)) dut (
    .clk(clk), .rst(rst), .i2c_scl(scl), .i2c_sda(sda),
    .data_out(data_out), .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy));

  always @(negedge clk) begin
    if (frame_valid) valid_cnt++;
    if (frame_err) err_cnt++;
    if (busy) busy_seen = 1'b1;
  end

  // frame contents: byte i lands at bits [FW-1-8i -: 8]
  function automatic logic [FW-1:0] pack(input logic [7:0] b[$]);
    logic [FW-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[FW-1-8*i -: 8] = b[i];
    return r;
  endfunction

  // bit 0 = address ACK, bit i = ACK of data byte i
  function automatic logic [31:0] exp_acks(input bit matched, input int n);
    int k;
    k = (n < NB) ? n : NB;
    return matched ? ((32'd1 << (k + 1)) - 32'd1) : 32'd0;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_clks(Q);
    scl = 1'b1;       wait_clks(Q);
    m_sda_low = 1'b1; wait_clks(Q);
    scl = 1'b0;       wait_clks(Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda_low = ~b[i]; wait_clks(Q);
      scl = 1'b1;        wait_clks(Q);
      scl = 1'b0;        wait_clks(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    m_sda_low = 1'b0; wait_clks(Q);
    scl = 1'b1;       wait_clks(Q/2);
    ack = (sda === 1'b0);
    wait_clks(Q/2);
    scl = 1'b0;       wait_clks(Q);
  endtask

  task automatic send_seq(input logic [7:0] addr, input logic [7:0] bytes[$], output logic [31:0] acks);
    logic a;
    acks = '0;
    i2c_start();
    send_byte(addr, a);
    acks[0] = a;
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i], a);
      acks[i+1] = a;
    end
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_clks(Q);
    scl = 1'b1;       wait_clks(Q);
    m_sda_low = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      lat_trace[k] = frame_valid;
    end
    wait_clks(Q);
  endtask

  task automatic rand_bytes(input int n, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wait_clks(3);
    scl = 1'b0; m_sda_low = 1'b1; wait_clks(2);
    scl = 1'b1; wait_clks(2);
    m_sda_low = 1'b0; wait_clks(2);
    cmp_cnt++; if (data_out !== '0) begin mis_cnt++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
    cmp_cnt++; if (frame_valid !== 1'b0) begin mis_cnt++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
    cmp_cnt++; if (frame_err !== 1'b0) begin mis_cnt++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    cmp_cnt++; if (busy !== 1'b0) begin mis_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
    cmp_cnt++; if (sda !== 1'b1) begin mis_cnt++; $display("FAIL reset_sda: got %b expected 1 (released)", sda); end
    rst = 1'b1;
    wait_clks(10);
    cmp_cnt++; if (valid_cnt + err_cnt != 0 || busy_seen) begin mis_cnt++; $display("FAIL reset_quiet: got pulses %0d busy_seen %b expected 0 0", valid_cnt + err_cnt, busy_seen); end
  endtask

  task automatic test_full_frame();
    logic [7:0] q[$];
    logic [31:0] acks;
    int v0, e0;
    q = {};
    for (int i = 1; i <= NB; i++) q.push_back(8'(i));
    v0 = valid_cnt; e0 = err_cnt;
    send_seq(8'h0E, q, acks);
    cmp_cnt++; if (acks !== exp_acks(1'b1, NB)) begin mis_cnt++; $display("FAIL full_acks: got %h expected %h", acks, exp_acks(1'b1, NB)); end
    cmp_cnt++; if (busy !== 1'b1) begin mis_cnt++; $display("FAIL full_busy_mid: got %b expected 1", busy); end
    i2c_stop();
    exp_data = pack(q);
    cmp_cnt++; if (lat_trace !== (8'd1 << (LAT-1))) begin mis_cnt++; $display("FAIL full_valid_timing: got %b expected %b", lat_trace, 8'd1 << (LAT-1)); end
    cmp_cnt++; if (data_out !== exp_data) begin mis_cnt++; $display("FAIL full_data: got %h expected %h", data_out, exp_data); end
    cmp_cnt++; if (valid_cnt - v0 != 1 || err_cnt - e0 != 0) begin mis_cnt++; $display("FAIL full_pulses: got valid %0d err %0d expected 1 0", valid_cnt - v0, err_cnt - e0); end
    cmp_cnt++; if (busy !== 1'b0) begin mis_cnt++; $display("FAIL full_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_nack_addr();
    logic [7:0] addrs[2];
    logic [7:0] q[$];
    logic [31:0] acks;
    int v0, e0;
    addrs[0] = 8'h0F; addrs[1] = 8'h10;
    for (int a = 0; a < 2; a++) begin
      rand_bytes(2, q);
      v0 = valid_cnt; e0 = err_cnt; busy_seen = 1'b0;
      send_seq(addrs[a], q, acks);
      i2c_stop();
      cmp_cnt++; if (acks !== 32'd0) begin mis_cnt++; $display("FAIL nack_acks[%h]: got %h expected 0", addrs[a], acks); end
      cmp_cnt++; if (busy_seen !== 1'b0) begin mis_cnt++; $display("FAIL nack_busy[%h]: got %b expected 0", addrs[a], busy_seen); end
      cmp_cnt++; if (valid_cnt - v0 != 0 || err_cnt - e0 != 0) begin mis_cnt++; $display("FAIL nack_pulses[%h]: got valid %0d err %0d expected 0 0", addrs[a], valid_cnt - v0, err_cnt - e0); end
      cmp_cnt++; if (data_out !== exp_data) begin mis_cnt++; $display("FAIL nack_data[%h]: got %h expected %h", addrs[a], data_out, exp_data); end
    end
  endtask

  task automatic test_short_frame();
    logic [7:0] q[$];
    logic [31:0] acks;
    int v0, e0;
    rand_bytes(5, q);
    v0 = valid_cnt; e0 = err_cnt;
    send_seq(8'h0E, q, acks);
    i2c_stop();
    cmp_cnt++; if (acks !== exp_acks(1'b1, 5)) begin mis_cnt++; $display("FAIL short_acks: got %h expected %h", acks, exp_acks(1'b1, 5)); end
    cmp_cnt++; if (valid_cnt - v0 != 0 || err_cnt - e0 != 1) begin mis_cnt++; $display("FAIL short_pulses: got valid %0d err %0d expected 0 1", valid_cnt - v0, err_cnt - e0); end
    cmp_cnt++; if (data_out !== exp_data) begin mis_cnt++; $display("FAIL short_data_hold: got %h expected %h", data_out, exp_data); end
  endtask

  task automatic test_overflow();
    logic [7:0] q[$];
    logic [31:0] acks;
    int v0, e0;
    rand_bytes(NB + 1, q);
    v0 = valid_cnt; e0 = err_cnt;
    send_seq(8'h0E, q, acks);
    i2c_stop();
    cmp_cnt++; if (acks !== exp_acks(1'b1, NB + 1)) begin mis_cnt++; $display("FAIL ovf_acks: got %h expected %h", acks, exp_acks(1'b1, NB + 1)); end
    cmp_cnt++; if (valid_cnt - v0 != 0 || err_cnt - e0 != 1) begin mis_cnt++; $display("FAIL ovf_pulses: got valid %0d err %0d expected 0 1", valid_cnt - v0, err_cnt - e0); end
    cmp_cnt++; if (data_out !== exp_data) begin mis_cnt++; $display("FAIL ovf_data_hold: got %h expected %h", data_out, exp_data); end
  endtask

  task automatic test_repeated_start();
    logic [7:0] q0[$];
    logic [7:0] q[$];
    logic [31:0] acks0, acks;
    int v0, e0;
    rand_bytes(4, q0);
    q = {};
    for (int i = 0; i < NB; i++) q.push_back(8'(8'hA0 + i));
    v0 = valid_cnt; e0 = err_cnt;
    send_seq(8'h0E, q0, acks0);
    send_seq(8'h0E, q, acks);
    i2c_stop();
    exp_data = pack(q);
    cmp_cnt++; if (acks0 !== exp_acks(1'b1, 4) || acks !== exp_acks(1'b1, NB)) begin mis_cnt++; $display("FAIL rstart_acks: got %h/%h expected %h/%h", acks0, acks, exp_acks(1'b1, 4), exp_acks(1'b1, NB)); end
    cmp_cnt++; if (valid_cnt - v0 != 1 || err_cnt - e0 != 0) begin mis_cnt++; $display("FAIL rstart_pulses: got valid %0d err %0d expected 1 0", valid_cnt - v0, err_cnt - e0); end
    cmp_cnt++; if (data_out !== exp_data) begin mis_cnt++; $display("FAIL rstart_data: got %h expected %h", data_out, exp_data); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    logic [31:0] acks;
    int v0, e0;
    rand_bytes(5, q);
    v0 = valid_cnt; e0 = err_cnt;
    send_seq(8'h0E, q, acks);
    send_bits(8'($urandom));
    m_sda_low = 1'b0; wait_clks(Q);
    cmp_cnt++; if (sda !== 1'b0) begin mis_cnt++; $display("FAIL rmid_ack_driven: got %b expected 0", sda); end
    rst = 1'b0; #1;
    cmp_cnt++; if (sda !== 1'b1) begin mis_cnt++; $display("FAIL rmid_sda_release: got %b expected 1", sda); end
    cmp_cnt++; if (data_out !== '0 || frame_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin mis_cnt++; $display("FAIL rmid_outputs: got data %h v %b e %b busy %b expected all 0", data_out, frame_valid, frame_err, busy); end
    exp_data = '0;
    wait_clks(2);
    scl = 1'b1; wait_clks(3);
    rst = 1'b1; wait_clks(Q);
    cmp_cnt++; if (valid_cnt - v0 != 0 || err_cnt - e0 != 0) begin mis_cnt++; $display("FAIL rmid_pulses: got valid %0d err %0d expected 0 0", valid_cnt - v0, err_cnt - e0); end
    rand_bytes(NB, q);
    send_seq(8'h0E, q, acks);
    i2c_stop();
    exp_data = pack(q);
    cmp_cnt++; if (acks !== exp_acks(1'b1, NB)) begin mis_cnt++; $display("FAIL rmid_next_acks: got %h expected %h", acks, exp_acks(1'b1, NB)); end
    cmp_cnt++; if (data_out !== exp_data || valid_cnt - v0 != 1) begin mis_cnt++; $display("FAIL rmid_next_frame: got %h valid %0d expected %h 1", data_out, valid_cnt - v0, exp_data); end
  endtask

  task automatic test_random();
    logic [7:0] q0[$];
    logic [7:0] q[$];
    logic [31:0] acks0, acks;
    logic [7:0] addr;
    bit matched, use_rs;
    int n, k, v0, e0, exp_v, exp_e;
    for (int it = 0; it < 8; it++) begin
      addr    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0E;
      matched = (addr == 8'h0E);
      n       = (it == 0) ? 0 : $urandom_range(0, NB + 2);
      use_rs  = ($urandom_range(0, 2) == 0);
      k       = $urandom_range(1, 4);
      v0 = valid_cnt; e0 = err_cnt;
      if (use_rs) begin
        rand_bytes(k, q0);
        send_seq(8'h0E, q0, acks0);
        cmp_cnt++; if (acks0 !== exp_acks(1'b1, k)) begin mis_cnt++; $display("FAIL rand%0d_pre_acks: got %h expected %h", it, acks0, exp_acks(1'b1, k)); end
      end
      rand_bytes(n, q);
      send_seq(addr, q, acks);
      i2c_stop();
      exp_v = (matched && n == NB) ? 1 : 0;
      exp_e = (matched && n > 0 && n != NB) ? 1 : 0;
      if (exp_v == 1) exp_data = pack(q);
      cmp_cnt++; if (acks !== exp_acks(matched, n)) begin mis_cnt++; $display("FAIL rand%0d_acks: addr %h n %0d got %h expected %h", it, addr, n, acks, exp_acks(matched, n)); end
      cmp_cnt++; if (valid_cnt - v0 != exp_v || err_cnt - e0 != exp_e) begin mis_cnt++; $display("FAIL rand%0d_pulses: addr %h n %0d got valid %0d err %0d expected %0d %0d", it, addr, n, valid_cnt - v0, err_cnt - e0, exp_v, exp_e); end
      cmp_cnt++; if (data_out !== exp_data) begin mis_cnt++; $display("FAIL rand%0d_data: got %h expected %h", it, data_out, exp_data); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_nack_addr();
    test_short_frame();
    test_overflow();
    test_repeated_start();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
